// File: rtl/llc_bus_responder_if.sv
// Bus-side bundle between the LLC, peer snoopers and memory for llc_bus_responder.
// The responder uses the slave modport; the LLC/peer/memory side uses master.
interface llc_bus_responder_if #(
  parameter int ADDR_BITS    = 32,
  parameter int NUM_SNOOPERS = 3
);
  logic                      req_valid;
  logic                      req_ready;
  logic [1:0]                req_op;
  logic [ADDR_BITS-1:0]      req_addr;
  logic                      rsp_valid;
  logic [1:0]                rsp_snoop;
  logic                      rsp_timeout;
  logic                      snp_valid;
  logic [1:0]                snp_op;
  logic [ADDR_BITS-1:0]      snp_addr;
  logic [NUM_SNOOPERS-1:0]   snp_rslt_valid;
  logic [2*NUM_SNOOPERS-1:0] snp_rslt;
  logic                      wb_valid;
  logic                      mem_valid;
  logic                      mem_write;
  logic [ADDR_BITS-1:0]      mem_addr;
  logic                      mem_ready;

  modport slave (
    input  req_valid, req_op, req_addr, snp_rslt_valid, snp_rslt, wb_valid, mem_ready,
    output req_ready, rsp_valid, rsp_snoop, rsp_timeout, snp_valid, snp_op, snp_addr,
           mem_valid, mem_write, mem_addr
  );

  modport master (
    output req_valid, req_op, req_addr, snp_rslt_valid, snp_rslt, wb_valid, mem_ready,
    input  req_ready, rsp_valid, rsp_snoop, rsp_timeout, snp_valid, snp_op, snp_addr,
           mem_valid, mem_write, mem_addr
  );
endinterface

// File: rtl/llc_bus_responder.sv
// Shared-bus responder: broadcasts one LLC bus op as a snoop, merges peer results,
// waits out any HITM writeback, runs the memory access and returns the merged result.
//
// state     | meaning
// S_IDLE    | ready for a new bus op
// S_SNOOP   | one-cycle snoop broadcast, per-snooper flags restart
// S_COLLECT | gathering snoop results until all answer or timeout
// S_WB_WAIT | merged HITM on READ/RWIM, waiting for owner writeback
// S_MEM     | memory request held until accepted
// S_RESP    | one-cycle completion pulse back to the LLC
module llc_bus_responder #(
  parameter int ADDR_BITS     = 32,
  parameter int NUM_SNOOPERS  = 3,
  parameter int SNOOP_TIMEOUT = 15
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  llc_bus_responder_if.slave  io_bus
);
  localparam int CW = ($clog2(SNOOP_TIMEOUT + 1) < 4) ? 4 : $clog2(SNOOP_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(SNOOP_TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(SNOOP_TIMEOUT - 1);
  localparam logic [1:0] OP_WRITE = 2'b01, OP_INV = 2'b10;
  localparam logic [1:0] SN_HIT = 2'b00, SN_HITM = 2'b01, SN_NOHIT = 2'b10;

  typedef enum logic [2:0] {S_IDLE, S_SNOOP, S_COLLECT, S_WB_WAIT, S_MEM, S_RESP} state_t;

  state_t                    r_state;
  logic [1:0]                r_op;
  logic [ADDR_BITS-1:0]      r_addr;
  logic [NUM_SNOOPERS-1:0]   r_got;
  logic [2*NUM_SNOOPERS-1:0] r_rslt;
  logic [CW-1:0]             r_cnt;
  logic [1:0]                r_merged;
  logic                      r_tmo;
  logic                      r_req_ready, r_rsp_valid, r_rsp_timeout, r_snp_valid;
  logic                      r_mem_valid, r_mem_write;
  logic [1:0]                r_rsp_snoop;

  logic [NUM_SNOOPERS-1:0]   w_got_nxt;
  logic [2*NUM_SNOOPERS-1:0] w_rslt_nxt;
  logic [1:0]                w_merged;
  logic                      w_any_hitm, w_any_hit, w_all_got, w_cnt_done;
  logic [CW-1:0]             w_cnt_inc;

  // A snooper's first strobe wins; unanswered snoopers and code 11 merge as NOHIT.
  always_comb begin
    w_got_nxt  = r_got | io_bus.snp_rslt_valid;
    w_rslt_nxt = r_rslt;
    w_any_hitm = 1'b0;
    w_any_hit  = 1'b0;
    for (int i = 0; i < NUM_SNOOPERS; i++) begin
      if (!r_got[i] && io_bus.snp_rslt_valid[i])
        w_rslt_nxt[2*i +: 2] = io_bus.snp_rslt[2*i +: 2];
    end
    for (int i = 0; i < NUM_SNOOPERS; i++) begin
      if (w_got_nxt[i] && (w_rslt_nxt[2*i +: 2] == SN_HITM)) w_any_hitm = 1'b1;
      if (w_got_nxt[i] && (w_rslt_nxt[2*i +: 2] == SN_HIT))  w_any_hit  = 1'b1;
    end
    w_merged = w_any_hitm ? SN_HITM : (w_any_hit ? SN_HIT : SN_NOHIT);
  end

  assign w_all_got  = &w_got_nxt;
  assign w_cnt_done = (r_cnt >= CNT_LAST);
  assign w_cnt_inc  = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_op          <= 2'b00;
      r_addr        <= '0;
      r_got         <= '0;
      r_rslt        <= '0;
      r_cnt         <= '0;
      r_merged      <= SN_NOHIT;
      r_tmo         <= 1'b0;
      r_req_ready   <= 1'b1;
      r_rsp_valid   <= 1'b0;
      r_rsp_snoop   <= SN_NOHIT;
      r_rsp_timeout <= 1'b0;
      r_snp_valid   <= 1'b0;
      r_mem_valid   <= 1'b0;
      r_mem_write   <= 1'b0;
    end else begin
      r_snp_valid <= 1'b0;
      r_rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (io_bus.req_valid) begin
            r_op        <= io_bus.req_op;
            r_addr      <= io_bus.req_addr;
            r_req_ready <= 1'b0;
            r_tmo       <= 1'b0;
            if (io_bus.req_op == OP_WRITE) begin
              r_merged    <= SN_NOHIT;
              r_mem_valid <= 1'b1;
              r_mem_write <= 1'b1;
              r_state     <= S_MEM;
            end else begin
              r_snp_valid <= 1'b1;
              r_state     <= S_SNOOP;
            end
          end
        end
        S_SNOOP: begin
          r_got   <= io_bus.snp_rslt_valid;
          r_rslt  <= io_bus.snp_rslt;
          r_cnt   <= '0;
          r_state <= S_COLLECT;
        end
        S_COLLECT: begin
          r_got  <= w_got_nxt;
          r_rslt <= w_rslt_nxt;
          r_cnt  <= w_cnt_inc;
          if (w_all_got || w_cnt_done) begin
            r_merged <= w_merged;
            r_tmo    <= !w_all_got;
            r_cnt    <= '0;
            if (r_op == OP_INV) begin
              r_rsp_valid   <= 1'b1;
              r_rsp_snoop   <= w_merged;
              r_rsp_timeout <= !w_all_got;
              r_state       <= S_RESP;
            end else if (w_merged == SN_HITM) begin
              r_state <= S_WB_WAIT;
            end else begin
              r_mem_valid <= 1'b1;
              r_mem_write <= 1'b0;
              r_state     <= S_MEM;
            end
          end
        end
        S_WB_WAIT: begin
          r_cnt <= w_cnt_inc;
          if (io_bus.wb_valid || w_cnt_done) begin
            if (!io_bus.wb_valid) r_tmo <= 1'b1;
            r_mem_valid <= 1'b1;
            r_mem_write <= 1'b0;
            r_state     <= S_MEM;
          end
        end
        S_MEM: begin
          if (io_bus.mem_ready) begin
            r_mem_valid   <= 1'b0;
            r_mem_write   <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_rsp_snoop   <= r_merged;
            r_rsp_timeout <= r_tmo;
            r_state       <= S_RESP;
          end
        end
        S_RESP: begin
          r_req_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign io_bus.req_ready   = r_req_ready;
  assign io_bus.rsp_valid   = r_rsp_valid;
  assign io_bus.rsp_snoop   = r_rsp_snoop;
  assign io_bus.rsp_timeout = r_rsp_timeout;
  assign io_bus.snp_valid   = r_snp_valid;
  assign io_bus.snp_op      = r_op;
  assign io_bus.snp_addr    = r_addr;
  assign io_bus.mem_valid   = r_mem_valid;
  assign io_bus.mem_write   = r_mem_write;
  assign io_bus.mem_addr    = r_addr;
endmodule
